// File: rtl/decode_pipe.sv
// Single-stage instruction decode with register file read, write-first bypass and registered output bundle.
// Define DECODE_SCOREBOARD_EN to enable per-register busy tracking and hazard stalls.
module decode_pipe #(
    parameter  int XLEN        = 64,
    parameter  int NUM_REGS    = 32,
    parameter  int INSTR_WIDTH = 32,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [63:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_pc,
    output logic [XLEN-1:0]        out_val_a,
    output logic [XLEN-1:0]        out_val_b,
    output logic [XLEN-1:0]        out_imm,
    output logic [RW-1:0]          out_dest,
    output logic [6:0]             out_opcode,
    output logic [2:0]             out_funct3,
    output logic [6:0]             out_funct7,
    output logic                   out_illegal,
    input  logic                   wb_en,
    input  logic [RW-1:0]          wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_BAD} fmt_t;

    logic [XLEN-1:0] regs [NUM_REGS];
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1, rs2, rd, dest;
    fmt_t            fmt;
    logic            use_rs1, use_rs2, has_dest;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, val_a, val_b;
    logic            hazard, accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rd     = RW'(in_instr[11:7]);
    assign rs1    = RW'(in_instr[19:15]);
    assign rs2    = RW'(in_instr[24:20]);

    always_comb begin
        fmt      = FMT_BAD;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        has_dest = 1'b0;
        case (opcode)
            OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_OPIMM32, OPC_SYSTEM: begin
                fmt = FMT_I; use_rs1 = 1'b1; has_dest = 1'b1;
            end
            OPC_STORE:  begin fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_BRANCH: begin fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; has_dest = 1'b1; end
            OPC_JAL:    begin fmt = FMT_J; has_dest = 1'b1; end
            OPC_OP, OPC_OP32: begin
                fmt = FMT_R; use_rs1 = 1'b1; use_rs2 = 1'b1; has_dest = 1'b1;
            end
            default: fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm  = {{(XLEN-32){imm32[31]}}, imm32};
    assign dest = has_dest ? rd : '0;

    // Write-first: a same-cycle write-back to a source register wins over the stored value.
    always_comb begin
        val_a = '0;
        val_b = '0;
        if (use_rs1 && rs1 != '0)
            val_a = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
        if (use_rs2 && rs2 != '0)
            val_b = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;

    // Set is issued after clear so a same-register set/clear leaves the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (wb_en)
                busy[wb_rd] <= 1'b0;
            if (accept && dest != '0)
                busy[dest] <= 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && rs1 != '0 && busy[rs1] && !(wb_en && wb_rd == rs1))
            hazard = 1'b1;
        if (use_rs2 && rs2 != '0 && busy[rs2] && !(wb_en && wb_rd == rs2))
            hazard = 1'b1;
        if (dest != '0 && busy[dest] && !(wb_en && wb_rd == dest))
            hazard = 1'b1;
    end
`else
    assign hazard = 1'b0;
`endif

    assign in_ready = reset & (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_val_a   <= '0;
            out_val_b   <= '0;
            out_imm     <= '0;
            out_dest    <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_val_a   <= val_a;
            out_val_b   <= val_b;
            out_imm     <= imm;
            out_dest    <= dest;
            out_opcode  <= opcode;
            out_funct3  <= funct3;
            out_funct7  <= funct7;
            out_illegal <= (fmt == FMT_BAD);
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL expose parameters: XLEN, default 64, datapath/register width; NUM_REGS, default 32, architectural register count (power of two, index width RW=log2(NUM_REGS)); INSTR_WIDTH, default 32, instruction width.
REQ-002 The block SHALL have these ports:
  clk  in  1  sole clock, rising edge;
  reset  in  1  asynchronous, active-low reset;
  in_valid  in  1  upstream instruction valid;
  in_ready  out  1  decode can accept;
  in_instr  in  INSTR_WIDTH  instruction bits;
  in_pc  in  64  instruction PC;
  out_valid  out  1  decoded bundle valid;
  out_ready  in  1  downstream accepts;
  out_pc  out  64  registered PC;
  out_val_a  out  XLEN  rs1 operand;
  out_val_b  out  XLEN  rs2 operand;
  out_imm  out  XLEN  sign-extended immediate;
  out_dest  out  RW  destination register, 0 if none;
  out_opcode  out  7 / out_funct3 out 3 / out_funct7 out 7  raw fields;
  out_illegal  out  1  unrecognised opcode;
  wb_en  in  1 / wb_rd  in  RW / wb_data  in  XLEN  write-back port;
  flush  in  1  squash pipeline.

Function
REQ-003 Register file SHALL hold NUM_REGS x XLEN; register 0 reads 0 and ignores writes; write on rising clk when wb_en=1 and wb_rd!=0.
REQ-004 Reads SHALL be combinational with write-first bypass: if wb_en=1, wb_rd==rsN and rsN!=0, the operand SHALL equal wb_data.
REQ-005 Immediate by opcode: I for 0010011/0000011/1100111/0011011/1110011; S for 0100011; B for 1100011; U for 0110111/0010111; J for 1101111; 0 for 0110011/0111011; all sign-extended to XLEN.
REQ-006 Any other opcode SHALL set out_illegal=1, out_dest=0, out_imm=0.
REQ-007 rs1 is used by all legal opcodes except LUI, AUIPC and JAL; rs2 is used only by OP, OP-32, STORE and BRANCH; an unused operand SHALL read 0.
REQ-008 out_dest SHALL be rd for legal opcodes other than STORE and BRANCH, else 0.
REQ-009 Handshake: accept when in_valid & in_ready; decoded bundle registered, latency exactly 1 cycle; in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-010 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-011 When out_ready=1 and no new accept occurs, out_valid SHALL clear on the next edge.
REQ-012 flush=1 SHALL clear out_valid on the next edge, block acceptance that cycle, and clear all scoreboard bits; register file contents are unaffected.
REQ-013 Operands captured at accept SHALL NOT be updated by later write-backs while stalled at the output.

Reset
REQ-014 On reset low, asynchronously: out_valid=0, out_pc=0, out_val_a=0, out_val_b=0, out_imm=0, out_dest=0, out_opcode=0, out_funct3=0, out_funct7=0, out_illegal=0, all scoreboard bits 0, all registers 0.
REQ-015 While reset is low, in_ready SHALL be 0; reset asserted mid-transfer SHALL discard the held bundle.

Configuration
REQ-016 Macro DECODE_SCOREBOARD_EN defined: a busy bit per register SHALL be set on accept of a legal instruction with out_dest!=0 and cleared on wb_en with matching wb_rd; a simultaneous set and clear of the same register SHALL leave it set.
REQ-017 With the macro defined, hazard = a used rs1/rs2, or the new rd, is busy and not being bypassed this cycle by wb_en/wb_rd; register 0 never hazards.
REQ-018 Macro undefined: no scoreboard storage, hazard=0, behaviour otherwise identical.

Verification
REQ-019 0x00500093 (addi x1,x0,5), pc 0x1000, out_ready=1 -> next cycle out_valid=1, out_imm=5, out_dest=1, out_val_a=0, out_pc=0x1000.
REQ-020 0xFFF00093 -> out_imm=0xFFFF_FFFF_FFFF_FFFF; opcode 0x7F -> out_illegal=1, out_dest=0.
REQ-021 wb_en=1, wb_rd=2, wb_data=0xDEAD in the same cycle that 0x002101B3 (add x3,x2,x2) is accepted -> out_val_a=out_val_b=0xDEAD.
REQ-022 DECODE_SCOREBOARD_EN: accept addi x1, then present 0x001081B3 -> in_ready=0 until the wb_rd=1 cycle, accepted that cycle with out_val_a=wb_data.
REQ-023 Hold out_ready=0 for 3 cycles after accept -> outputs stable and in_ready=0; then flush=1 -> out_valid=0 next cycle and busy bits cleared.
REQ-024 Assert reset low mid-stall -> all outputs reach reset values immediately without a clock edge.
